// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared pointer helpers for both sides of the async FIFO
package afifo_pkg;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // Operates on a 32-bit container; callers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_wptr_full_if.sv
// rtl/afifo_wptr_full_if.sv - write-side pointer/flag bundle of the async FIFO
interface afifo_wptr_full_if #(parameter int AW = 4);
  logic          winc;
  logic          woverflow_clr;
  logic [AW:0]   rgray_async;
  logic          wenc;
  logic [AW-1:0] waddr;
  logic [AW:0]   wgray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wcount;
  logic          woverflow;

  modport master (
    output winc, woverflow_clr, rgray_async,
    input  wenc, waddr, wgray, wfull, walmost_full, wcount, woverflow
  );

  modport slave (
    input  winc, woverflow_clr, rgray_async,
    output wenc, waddr, wgray, wfull, walmost_full, wcount, woverflow
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to zero
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/afifo_wptr_full.sv
// rtl/afifo_wptr_full.sv - write pointer, full/almost-full and overflow tracking
module afifo_wptr_full
  import afifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic              wclk,
  input  logic              wrstn,
  afifo_wptr_full_if.slave  wif
);

  localparam int AW = aw_of(DEPTH);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic        wfull_q, wfull_d;
  logic        woverflow_q, woverflow_d;
  logic [AW:0] rq2;
  logic [AW:0] rbin;
  logic [AW:0] full_gray;
  logic [AW:0] wcount;
  logic        wenc;

  sync_2ff #(.W(AW+1)) u_rsync (
    .clk  (wclk),
    .rstn (wrstn),
    .d    (wif.rgray_async),
    .q    (rq2)
  );

  always_comb begin
    // Held low during reset so an in-flight write never reaches the RAM.
    wenc        = wif.winc & ~wfull_q & wrstn;
    wbin_d      = wbin_q + (AW+1)'(wenc);
    wgray_d     = (AW+1)'(bin2gray(32'(wbin_d)));
    rbin        = (AW+1)'(gray2bin(32'(rq2)));
    full_gray   = {~rq2[AW:AW-1], rq2[AW-2:0]};
    wfull_d     = (wgray_d == full_gray);
    wcount      = wbin_q - rbin;
    woverflow_d = (wif.winc & wfull_q) | (woverflow_q & ~wif.woverflow_clr);
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign wif.wenc         = wenc;
  assign wif.waddr        = wbin_q[AW-1:0];
  assign wif.wgray        = wgray_q;
  assign wif.wfull        = wfull_q;
  assign wif.wcount       = wcount;
  assign wif.walmost_full = (wcount >= (AW+1)'(AF_LEVEL));
  assign wif.woverflow    = woverflow_q;

endmodule
